// File: rtl/dcache_dm_if.sv
// Backing-memory request/ready bus between the data cache (master) and memory (slave).
// All request fields stay stable from mem_req rising until the cycle mem_ready is seen.
interface dcache_mem_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDRESS_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic                      mem_ready;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache, one 32-bit word per line.
// Loads hit combinationally; misses refill over the memory bus while stall holds the pipeline.
module dcache_dm #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INDEX_BITS    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      re,
    input  logic                      we,
    input  logic [2:0]                funct3,
    input  logic [ADDRESS_WIDTH-1:0]  daddr,
    input  logic [DATA_WIDTH-1:0]     wd_data,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      cache_hit,
    output logic                      stall,
    dcache_mem_if.master              mem
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                     state_q;
    logic [LINES-1:0]           valid_q;
    logic [TAG_BITS-1:0]        tag_q [LINES];
    logic                       mem_req_q;
    logic                       mem_we_q;
    logic [ADDRESS_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]      mem_wdata_q;
    logic [3:0]                 mem_wstrb_q;
    logic                       wr_done_q;

    logic [1:0]                 offset;
    logic [INDEX_BITS-1:0]      index;
    logic [TAG_BITS-1:0]        tag;
    logic [DATA_WIDTH-1:0]      line_word;
    logic                       hit;
    logic                       refill_fire;
    logic                       write_fire;

    assign offset = daddr[1:0];
    assign index  = daddr[INDEX_BITS+1:2];
    assign tag    = daddr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign hit    = valid_q[index] && (tag_q[index] == tag);

    assign refill_fire = (state_q == REFILL) && mem.mem_ready && !rst;
    assign write_fire  = (state_q == WRITE)  && mem.mem_ready && !rst;

    // Data array split into byte lanes so write-hits merge only the strobed bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [LINES];
            always_ff @(posedge clk) begin
                if (refill_fire) begin
                    lane_q[index] <= mem.mem_rdata[8*gi +: 8];
                end else if (write_fire && hit && mem_wstrb_q[gi]) begin
                    lane_q[index] <= mem_wdata_q[8*gi +: 8];
                end
            end
            assign line_word[8*gi +: 8] = lane_q[index];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (refill_fire) begin
            tag_q[index] <= tag;
        end
    end

    logic [3:0]            st_strb;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  store_ok;

    always_comb begin
        st_strb  = 4'b0000;
        st_data  = '0;
        store_ok = 1'b1;
        case (funct3)
            3'b000: begin
                st_strb = 4'b0001 << offset;
                st_data = {24'b0, wd_data[7:0]} << {offset, 3'b000};
            end
            3'b001: begin
                st_strb = daddr[1] ? 4'b1100 : 4'b0011;
                st_data = daddr[1] ? {wd_data[15:0], 16'b0} : {16'b0, wd_data[15:0]};
            end
            3'b010: begin
                st_strb = 4'b1111;
                st_data = wd_data;
            end
            default: store_ok = 1'b0;
        endcase
    end

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        byte_sel = line_word[{offset, 3'b000} +: 8];
        half_sel = daddr[1] ? line_word[31:16] : line_word[15:0];
        case (funct3)
            3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_data = {24'b0, byte_sel};
            3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_data = {16'b0, half_sel};
            default: ld_data = line_word;
        endcase
    end

    logic is_load, in_idle, load_hit, start_refill, start_write;

    // A store that just completed is still presented for one cycle; wr_done_q lets it retire.
    assign is_load      = re && !we;
    assign in_idle      = (state_q == IDLE) && !rst;
    assign load_hit     = in_idle && is_load && hit;
    assign start_refill = in_idle && is_load && !hit;
    assign start_write  = in_idle && we && store_ok && !wr_done_q;

    assign cache_hit = load_hit;
    assign rd_data   = load_hit ? ld_data : '0;
    assign stall     = !rst && ((state_q != IDLE) || start_refill || start_write);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            wr_done_q   <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_refill) begin
                        state_q     <= REFILL;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {daddr[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= 4'b0000;
                    end else if (start_write) begin
                        state_q     <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {daddr[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= st_data;
                        mem_wstrb_q <= st_strb;
                    end
                end
                REFILL: begin
                    if (mem.mem_ready) begin
                        state_q        <= IDLE;
                        mem_req_q      <= 1'b0;
                        valid_q[index] <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        wr_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
